// File: rtl/alu_result_stage.sv
// EX->MEM boundary register for the alu: decodes the instruction class at accept time and
// holds up to two results in a head/skid buffer so memory-stage backpressure never drops one.
module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       i_datain,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [2:0]        alu_flags,
    input  logic [DATA_W-1:0] gr2,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [4:0]        out_rd,
    output logic              out_wr_en,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              out_br_taken,
    output logic              out_exc_ovf,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  ovf_count
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [4:0]        rd;
        logic              wr_en;
        logic              mem_rd;
        logic              mem_wr;
        logic              br_taken;
        logic              exc_ovf;
        logic              illegal;
    } entry_t;

    // Classify one instruction; an empty slot is always all-zero so qualifiers read 0.
    function automatic entry_t decode_entry(
        input logic [5:0]        op,
        input logic [5:0]        funct,
        input logic [4:0]        rt,
        input logic [4:0]        rd,
        input logic              zero,
        input logic              ovf,
        input logic [DATA_W-1:0] c,
        input logic [DATA_W-1:0] sd
    );
        entry_t e;
        e            = '0;
        e.result     = c;
        e.store_data = sd;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                    6'b100110, 6'b100111, 6'b101010, 6'b101011: begin
                        e.wr_en = 1'b1;
                        e.rd    = rd;
                    end
                    default: e.illegal = 1'b1;
                endcase
                e.exc_ovf = ovf & ((funct == 6'b100000) | (funct == 6'b100010));
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110: begin
                e.wr_en   = 1'b1;
                e.rd      = rt;
                e.exc_ovf = ovf & (op == 6'b001000);
            end
            6'b100011: begin
                e.mem_rd = 1'b1;
                e.wr_en  = 1'b1;
                e.rd     = rt;
            end
            6'b101011: e.mem_wr   = 1'b1;
            6'b000100: e.br_taken = zero;
            6'b000101: e.br_taken = ~zero;
            default:   e.illegal  = 1'b1;
        endcase
        // A trapped result never commits, and r0 is never a write target.
        if (e.exc_ovf || (e.rd == 5'd0)) begin
            e.wr_en = 1'b0;
        end else begin
            e.wr_en = e.wr_en;
        end
        return e;
    endfunction

    entry_t             head_r, skid_r, head_n, skid_n, new_entry_s;
    logic               head_v_r, skid_v_r, head_v_n, skid_v_n;
    logic               in_ready_r;
    logic [CNT_W-1:0]   ovf_count_r, ovf_count_n;
    logic               accept_s, deliver_s;
    logic               unused_s;

    assign unused_s    = ^{i_datain[25:21], i_datain[10:6], alu_flags[0]};
    assign accept_s    = in_valid & in_ready_r;
    assign deliver_s   = head_v_r & out_ready;
    assign new_entry_s = decode_entry(i_datain[31:26], i_datain[5:0], i_datain[20:16],
                                      i_datain[15:11], alu_flags[2], alu_flags[1], alu_c, gr2);

    // Next-state of the two-entry buffer and the saturating trap counter.
    always_comb begin
        head_n      = head_r;
        skid_n      = skid_r;
        head_v_n    = head_v_r;
        skid_v_n    = skid_v_r;
        ovf_count_n = ovf_count_r;
        if (flush) begin
            head_n   = '0;
            skid_n   = '0;
            head_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (deliver_s) begin
            if (skid_v_r) begin
                head_n = skid_r;
                if (accept_s) begin
                    skid_n = new_entry_s;
                end else begin
                    skid_n   = '0;
                    skid_v_n = 1'b0;
                end
            end else if (accept_s) begin
                head_n = new_entry_s;
            end else begin
                head_n   = '0;
                head_v_n = 1'b0;
            end
        end else if (accept_s) begin
            if (head_v_r) begin
                skid_n   = new_entry_s;
                skid_v_n = 1'b1;
            end else begin
                head_n   = new_entry_s;
                head_v_n = 1'b1;
            end
        end else begin
            head_n = head_r;
        end
        if (deliver_s && head_r.exc_ovf && (ovf_count_r != {CNT_W{1'b1}})) begin
            ovf_count_n = ovf_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ovf_count_n = ovf_count_r;
        end
    end

    // State registers; in_ready is registered off the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r      <= '0;
            skid_r      <= '0;
            head_v_r    <= 1'b0;
            skid_v_r    <= 1'b0;
            in_ready_r  <= 1'b1;
            ovf_count_r <= '0;
        end else begin
            head_r      <= head_n;
            skid_r      <= skid_n;
            head_v_r    <= head_v_n;
            skid_v_r    <= skid_v_n;
            in_ready_r  <= ~(head_v_n & skid_v_n);
            ovf_count_r <= ovf_count_n;
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = head_v_r;
    assign out_result     = head_r.result;
    assign out_store_data = head_r.store_data;
    assign out_rd         = head_r.rd;
    assign out_wr_en      = head_r.wr_en;
    assign out_mem_rd     = head_r.mem_rd;
    assign out_mem_wr     = head_r.mem_wr;
    assign out_br_taken   = head_r.br_taken;
    assign out_exc_ovf    = head_r.exc_ovf;
    assign out_illegal    = head_r.illegal;
    assign ovf_count      = ovf_count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: hand-computed vectors checked with immediate assertions.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] i_datain = 32'd0;
    logic [31:0] alu_c = 32'd0;
    logic [2:0]  alu_flags = 3'd0;
    logic [31:0] gr2 = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_rd;
    logic        out_wr_en, out_mem_rd, out_mem_wr, out_br_taken, out_exc_ovf, out_illegal;
    logic [7:0]  ovf_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.DATA_W(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .i_datain(i_datain), .alu_c(alu_c), .alu_flags(alu_flags), .gr2(gr2),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_wr_en(out_wr_en), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_br_taken(out_br_taken), .out_exc_ovf(out_exc_ovf), .out_illegal(out_illegal),
        .ovf_count(ovf_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] c,
                         input logic [2:0] f, input logic [31:0] sd);
        in_valid  = v;
        i_datain  = ins;
        alu_c     = c;
        alu_flags = f;
        gr2       = sd;
    endtask

    initial begin
        // Reset
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_ovf_count", {56'd0, ovf_count}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_no_valid", {63'd0, out_valid}, 64'd0);

        // Plain add to r2
        out_ready = 1'b1;
        drive(1'b1, 32'h00201020, 32'h0000000A, 3'b000, 32'd0);
        tick();
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_result", {32'd0, out_result}, 64'h0A);
        chk("add_rd", {59'd0, out_rd}, 64'd2);
        chk("add_wr_en", {63'd0, out_wr_en}, 64'd1);
        chk("add_exc", {63'd0, out_exc_ovf}, 64'd0);

        // add overflow traps, addu overflow does not
        drive(1'b1, 32'h00201020, 32'h00000002, 3'b010, 32'd0);
        tick();
        chk("ovf_exc", {63'd0, out_exc_ovf}, 64'd1);
        chk("ovf_wr_en", {63'd0, out_wr_en}, 64'd0);
        chk("ovf_cnt_pre", {56'd0, ovf_count}, 64'd0);
        drive(1'b1, 32'h00201021, 32'h00000002, 3'b010, 32'd0);
        tick();
        chk("ovf_cnt_post", {56'd0, ovf_count}, 64'd1);
        chk("addu_exc", {63'd0, out_exc_ovf}, 64'd0);
        chk("addu_wr_en", {63'd0, out_wr_en}, 64'd1);
        drive(1'b0, 32'd0, 32'd0, 3'b000, 32'd0);
        tick();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: two held, third refused, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'h00201020, 32'h11, 3'b000, 32'd0);
        tick();
        chk("bp1_ready", {63'd0, in_ready}, 64'd1);
        chk("bp1_result", {32'd0, out_result}, 64'h11);
        drive(1'b1, 32'h00201020, 32'h22, 3'b000, 32'd0);
        tick();
        chk("bp2_ready", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 32'h00201020, 32'h33, 3'b000, 32'd0);
        tick();
        chk("bp3_ready", {63'd0, in_ready}, 64'd0);
        chk("bp3_stable", {32'd0, out_result}, 64'h11);
        drive(1'b0, 32'd0, 32'd0, 3'b000, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp4_valid", {63'd0, out_valid}, 64'd1);
        chk("bp4_result", {32'd0, out_result}, 64'h22);
        chk("bp4_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("bp5_empty", {63'd0, out_valid}, 64'd0);

        // Branches, store, load
        drive(1'b1, 32'h10000000, 32'd0, 3'b100, 32'd0);
        tick();
        chk("beq_taken", {63'd0, out_br_taken}, 64'd1);
        chk("beq_wr_en", {63'd0, out_wr_en}, 64'd0);
        drive(1'b1, 32'h14000000, 32'd0, 3'b100, 32'd0);
        tick();
        chk("bne_taken", {63'd0, out_br_taken}, 64'd0);
        drive(1'b1, 32'hAC200020, 32'h20, 3'b000, 32'h12345678);
        tick();
        chk("sw_mem_wr", {63'd0, out_mem_wr}, 64'd1);
        chk("sw_data", {32'd0, out_store_data}, 64'h12345678);
        chk("sw_wr_en", {63'd0, out_wr_en}, 64'd0);
        drive(1'b1, 32'h8C230004, 32'h44, 3'b000, 32'd0);
        tick();
        chk("lw_mem_rd", {63'd0, out_mem_rd}, 64'd1);
        chk("lw_rd", {59'd0, out_rd}, 64'd3);
        chk("lw_wr_en", {63'd0, out_wr_en}, 64'd1);

        // Illegal op, illegal funct, r0 destination
        drive(1'b1, 32'hFC000000, 32'd0, 3'b000, 32'd0);
        tick();
        chk("ill_op", {63'd0, out_illegal}, 64'd1);
        chk("ill_op_wr", {63'd0, out_wr_en}, 64'd0);
        drive(1'b1, 32'h00201001, 32'd0, 3'b000, 32'd0);
        tick();
        chk("ill_funct", {63'd0, out_illegal}, 64'd1);
        drive(1'b1, 32'h00200020, 32'h5, 3'b000, 32'd0);
        tick();
        chk("r0_rd", {59'd0, out_rd}, 64'd0);
        chk("r0_wr_en", {63'd0, out_wr_en}, 64'd0);
        chk("r0_legal", {63'd0, out_illegal}, 64'd0);

        // Flush with two held plus a same-cycle accept
        out_ready = 1'b0;
        drive(1'b1, 32'h00201020, 32'h66, 3'b000, 32'd0);
        tick();
        tick();
        chk("fl_full", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 3'b000, 32'd0);
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("fl_dropped", {63'd0, out_valid}, 64'd0);

        // Saturation of the trap counter (count is 1 here)
        out_ready = 1'b1;
        drive(1'b1, 32'h20220000, 32'h7, 3'b010, 32'd0);
        tick();
        chk("addi_exc", {63'd0, out_exc_ovf}, 64'd1);
        for (int i = 0; i < 259; i++) tick();
        drive(1'b0, 32'd0, 32'd0, 3'b000, 32'd0);
        tick();
        tick();
        chk("ovf_sat", {56'd0, ovf_count}, 64'd255);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(1'b1, 32'h00201020, 32'h77, 3'b000, 32'd0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_cnt", {56'd0, ovf_count}, 64'd0);
        chk("arst_result", {32'd0, out_result}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
